// File: rtl/log2_pkg.sv
// log2_pkg: shared constants and the per-stage pipeline record for the log2 unit.
// The record is sized from the constants below. Change the result format here,
// and keep the log2 module parameters in step with it.
package log2_pkg;

   localparam int LOG2_DATA_WIDTH = 8;
   localparam int LOG2_FRAC_BITS  = 5;
   localparam int LOG2_MANT_W     = 16;

   localparam int INT_BITS = $clog2(LOG2_DATA_WIDTH);
   localparam int LATENCY  = LOG2_FRAC_BITS + 3;

   // One slot of the squaring pipeline.
   // mant holds m in [1,2) with the hidden 1 at the MSB.
   // exp is the integer part of the result, found by leading-one detection.
   // frac collects result bits, shifting in at the LSB so the first bit ends at the MSB.
   // zero marks an operand of 0, whose result is forced to 0.
   typedef struct packed {
      logic [LOG2_MANT_W-1:0]    mant;
      logic [INT_BITS-1:0]       exp;
      logic [LOG2_FRAC_BITS-1:0] frac;
      logic                      zero;
   } stage_t;

endpackage

// File: rtl/log2_sq_stage.sv
// log2_sq_stage: one fractional-bit step of the log2 pipeline.
// It squares the mantissa and truncates the square to the top MANT_W+1 bits.
// A square of 2 or more yields result bit 1, and the square is halved back into [1,2).
module log2_sq_stage
   import log2_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  stage_t stage_i,
   output stage_t stage_o
);

   logic [2*LOG2_MANT_W-1:0] square;
   logic [LOG2_MANT_W:0]     square_top;
   logic                     result_bit;
   stage_t                   next_stage;

   // The square has 2*(MANT_W-1) fraction bits.
   // Dropping MANT_W-1 of them leaves 2 integer bits above MANT_W-1 fraction bits.
   // The top bit therefore means the square is 2 or more.
   always_comb begin
      square     = (2*LOG2_MANT_W)'(stage_i.mant) * (2*LOG2_MANT_W)'(stage_i.mant);
      square_top = (LOG2_MANT_W+1)'(square >> (LOG2_MANT_W - 1));
      result_bit = square_top[LOG2_MANT_W];
      next_stage.mant = result_bit ? square_top[LOG2_MANT_W:1] : square_top[LOG2_MANT_W-1:0];
      next_stage.exp  = stage_i.exp;
      next_stage.frac = (stage_i.frac << 1) | LOG2_FRAC_BITS'(result_bit);
      next_stage.zero = stage_i.zero;
   end

   // Register the stage so that each result bit costs exactly one cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stage_o <= '0;
      end else begin
         stage_o <= next_stage;
      end
   end

endmodule

// File: rtl/log2.sv
// log2: free-running, fully pipelined fixed-point base-2 logarithm.
// Output format is {zero pad, integer part, FRAC_BITS fraction bits}.
// The result is truncated, and an input of 0 yields 0.
// rstn_i is an asynchronous, active-HIGH reset, despite its name.
// Optional macro LOG2_ZERO_ERR_EN adds err_o.
// err_o is aligned with number_o and is high when that result came from an input of 0.
module log2
   import log2_pkg::*;
#(
   parameter int DATA_WIDTH = LOG2_DATA_WIDTH,
   parameter int FRAC_BITS  = LOG2_FRAC_BITS,
   parameter int MANT_W     = LOG2_MANT_W
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [DATA_WIDTH-1:0] number_i,
`ifdef LOG2_ZERO_ERR_EN
   output logic                  err_o,
`endif
   output logic [DATA_WIDTH-1:0] number_o
);

   // The pipeline record is sized from the package.
   // Refuse any parameter set that disagrees with it or is not a legal format.
   if (DATA_WIDTH != LOG2_DATA_WIDTH || FRAC_BITS != LOG2_FRAC_BITS ||
       MANT_W != LOG2_MANT_W || INT_BITS + FRAC_BITS > DATA_WIDTH ||
       MANT_W <= DATA_WIDTH) begin : g_param_check
      $error("log2: parameters disagree with log2_pkg or form an illegal format");
   end

   logic [DATA_WIDTH-1:0] number_q;
   logic [INT_BITS-1:0]   lod_exp;
   logic [DATA_WIDTH-1:0] lod_norm;
   stage_t                lod_stage;
   stage_t                lod_q;
   stage_t                sq_pipe [0:FRAC_BITS-1];
   stage_t                last_stage;
   logic                  unused_final_mant;

   // Stage 0: capture the operand.
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         number_q <= '0;
      end else begin
         number_q <= number_i;
      end
   end

   // Find the leading one, which is the integer part.
   // Then shift the operand so that this one sits at the mantissa MSB.
   always_comb begin
      lod_exp = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (number_q[i]) lod_exp = INT_BITS'(i);
      end
      lod_norm       = number_q << (INT_BITS'(DATA_WIDTH - 1) - lod_exp);
      lod_stage.mant = {lod_norm, {(MANT_W-DATA_WIDTH){1'b0}}};
      lod_stage.exp  = lod_exp;
      lod_stage.frac = '0;
      lod_stage.zero = (number_q == '0);
   end

   // Stage 1: register the normalised mantissa and exponent.
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         lod_q <= '0;
      end else begin
         lod_q <= lod_stage;
      end
   end

   for (genvar g = 0; g < FRAC_BITS; g++) begin : g_sq
      if (g == 0) begin : g_first
         log2_sq_stage u_sq (
            .clk_i   (clk_i),
            .rst_i   (rstn_i),
            .stage_i (lod_q),
            .stage_o (sq_pipe[g])
         );
      end else begin : g_next
         log2_sq_stage u_sq (
            .clk_i   (clk_i),
            .rst_i   (rstn_i),
            .stage_i (sq_pipe[g-1]),
            .stage_o (sq_pipe[g])
         );
      end
   end

   assign last_stage        = sq_pipe[FRAC_BITS-1];
   assign unused_final_mant = ^last_stage.mant;

   // Final stage: pack the integer and fraction fields, forcing 0 for a zero operand.
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         number_o <= '0;
      end else begin
         number_o <= last_stage.zero ? '0 : DATA_WIDTH'({last_stage.exp, last_stage.frac});
      end
   end

`ifdef LOG2_ZERO_ERR_EN
   // Flag results that came from a zero operand, in step with number_o.
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         err_o <= 1'b0;
      end else begin
         err_o <= last_stage.zero;
      end
   end
`endif

endmodule

// File: tb/tb_log2.sv
// tb_log2: directed and sweep checks for the log2 unit with default parameters (Q3.5).
// Inputs are driven and outputs are sampled on the falling clock edge.
// A result is therefore visible 8 falling edges after its operand is driven.
module tb_log2;

   localparam int LAT    = 8;
   localparam int FILLER = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] number_in;
   logic [7:0] number_out;
`ifdef LOG2_ZERO_ERR_EN
   logic       err_out;
`endif

   int check_count = 0;
   int fail_count  = 0;

   log2 dut (
      .clk_i    (clk),
      .rstn_i   (rst),
      .number_i (number_in),
`ifdef LOG2_ZERO_ERR_EN
      .err_o    (err_out),
`endif
      .number_o (number_out)
   );

   always #5 clk = ~clk;

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
      end
   endtask

   // The reference value is floor(32*log2(x)), which equals the MSB index of x^32.
   function automatic logic [7:0] ref_log2(input int x);
      logic [263:0] p;
      logic [7:0]   r;
      p = 264'd1;
      r = 8'h00;
      if (x == 0) return 8'h00;
      for (int k = 0; k < 32; k++) p = p * 264'(x);
      for (int i = 0; i < 264; i++) begin
         if (p[i]) r = 8'(i);
      end
      return r;
   endfunction

   // Drive a single operand between filler values.
   // The output must still be 0 one cycle early and must equal the expected value exactly on time.
   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] expected, input string tag);
      @(negedge clk);
      number_in = x;
      @(negedge clk);
      number_in = 8'(FILLER);
      repeat (LAT - 2) @(negedge clk);
      checkOutput({tag, "_early"}, number_out, 8'h00);
      @(negedge clk);
      checkOutput(tag, number_out, expected);
   endtask

   logic [7:0] vec_in  [7] = '{8'd1,  8'd2,  8'd4,  8'd128, 8'd3,  8'd10, 8'd255};
   logic [7:0] vec_exp [7] = '{8'h00, 8'h20, 8'h40, 8'hE0,  8'h32, 8'h6A, 8'hFF};

   initial begin
      rst       = 1'b1;
      number_in = 8'(FILLER);
      repeat (3) @(negedge clk);
      checkOutput("reset_state", number_out, 8'h00);
`ifdef LOG2_ZERO_ERR_EN
      checkOutput("reset_err", {7'd0, err_out}, 8'h00);
`endif
      rst = 1'b0;
      repeat (LAT) @(negedge clk);

      // Powers of two, then non-powers including the maximum input.
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vec_in[v], vec_exp[v], $sformatf("vec_%0d", vec_in[v]));
      end

      // A zero operand gives 0. With the error flag built in, the flag is high only for that result.
      @(negedge clk);
      number_in = 8'd0;
      @(negedge clk);
      number_in = 8'(FILLER);
      repeat (LAT - 2) @(negedge clk);
`ifdef LOG2_ZERO_ERR_EN
      checkOutput("zero_err_early", {7'd0, err_out}, 8'h00);
`endif
      @(negedge clk);
      checkOutput("zero", number_out, 8'h00);
`ifdef LOG2_ZERO_ERR_EN
      checkOutput("zero_err", {7'd0, err_out}, 8'h01);
`endif
      @(negedge clk);
`ifdef LOG2_ZERO_ERR_EN
      checkOutput("zero_err_after", {7'd0, err_out}, 8'h00);
`endif

      // Hold 3 constant. The output is 0 until the latency has elapsed, then it stays at 50.
      @(negedge clk);
      number_in = 8'd3;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checkOutput(k < LAT ? "hold_fill" : "hold", number_out, k < LAT ? 8'h00 : 8'd50);
      end
      number_in = 8'(FILLER);
      repeat (LAT) @(negedge clk);

      // Sweep 1..255 back to back and compare each result with the exact floor.
      for (int c = 0; c < 255 + LAT; c++) begin
         @(negedge clk);
         if (c >= LAT) checkOutput($sformatf("sweep_%0d", c - LAT + 1), number_out, ref_log2(c - LAT + 1));
         number_in = (c < 255) ? 8'(c + 1) : 8'(FILLER);
      end

      // Pulse reset between clock edges while 200 fills the pipeline.
      // The output clears at once, and nothing from before the pulse may come out afterwards.
      @(negedge clk);
      number_in = 8'd200;
      repeat (LAT + 2) @(negedge clk);
      checkOutput("pre_reset", number_out, 8'hF4);
      #2;
      rst       = 1'b1;
      number_in = 8'(FILLER);
      #1;
      checkOutput("reset_async", number_out, 8'h00);
      rst = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         checkOutput($sformatf("reset_flush_%0d", k), number_out, 8'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
